// File: rtl/finalprojectsoc_pio_poller.sv
// Avalon-MM read master that periodically polls a switch PIO and streams bit-change events.
// Optional debounce of changed samples is enabled by defining PIO_POLLER_DEBOUNCE_EN.
module finalprojectsoc_pio_poller #(
  parameter int unsigned DATA_W       = 10,
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned POLL_ADDR    = 0,
  parameter int unsigned POLL_DIV     = 50000,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic [DATA_W-1:0] cur_value,
  output logic [DATA_W-1:0] chg_data,
  output logic [DATA_W-1:0] chg_mask,
  output logic              chg_valid,
  input  logic              chg_ready,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StReq     = 2'd1;
  localparam logic [1:0] StWait    = 2'd2;
  localparam logic [1:0] StCapture = 2'd3;

  localparam int unsigned PCNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int unsigned LCNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [PCNT_W-1:0] PollReload = PCNT_W'(POLL_DIV - 1);
  localparam logic [LCNT_W-1:0] LatReload  = LCNT_W'(READ_LATENCY - 1);
  localparam logic [ADDR_W-1:0] PollAddr   = ADDR_W'(POLL_ADDR);

  logic [1:0]        state_q, state_d;
  logic [PCNT_W-1:0] poll_cnt_q, poll_cnt_d;
  logic [LCNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] cur_value_q, cur_value_d;
  logic              primed_q, primed_d;
  logic [DATA_W-1:0] chg_data_q, chg_data_d;
  logic [DATA_W-1:0] chg_mask_q, chg_mask_d;
  logic              chg_valid_q, chg_valid_d;
  logic              overrun_q, overrun_d;
  logic              fire;

`ifdef PIO_POLLER_DEBOUNCE_EN
  localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CNT + 1);
  logic [DATA_W-1:0] cand_q, cand_d;
  logic [DCNT_W-1:0] cand_cnt_q, cand_cnt_d, cnt_next;
  logic              cand_valid_q, cand_valid_d;
`else
  localparam int unsigned unused_debounce_cnt = DEBOUNCE_CNT;
`endif

  always_comb begin
    state_d     = state_q;
    poll_cnt_d  = poll_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    sample_d    = sample_q;
    cur_value_d = cur_value_q;
    primed_d    = primed_q;
    chg_data_d  = chg_data_q;
    chg_mask_d  = chg_mask_q;
    chg_valid_d = chg_valid_q;
    overrun_d   = overrun_q;
    fire        = 1'b0;
`ifdef PIO_POLLER_DEBOUNCE_EN
    cand_d       = cand_q;
    cand_cnt_d   = cand_cnt_q;
    cand_valid_d = cand_valid_q;
    cnt_next     = '0;
`endif

    if (chg_valid_q && chg_ready) chg_valid_d = 1'b0;
    if (clr_overrun) overrun_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (!enable) begin
          poll_cnt_d = PollReload;
        end else if (poll_cnt_q == '0) begin
          state_d = StReq;
        end else begin
          poll_cnt_d = poll_cnt_q - 1'b1;
        end
      end
      StReq: begin
        if (!avm_waitrequest) begin
          state_d   = StWait;
          lat_cnt_d = LatReload;
        end
      end
      StWait: begin
        if (lat_cnt_q == '0) begin
          state_d  = StCapture;
          sample_d = avm_readdata[DATA_W-1:0];
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      StCapture: begin
        state_d    = StIdle;
        poll_cnt_d = PollReload;
        if (!primed_q) begin
          cur_value_d = sample_q;
          primed_d    = 1'b1;
        end else if (sample_q != cur_value_q) begin
`ifdef PIO_POLLER_DEBOUNCE_EN
          cnt_next = (cand_valid_q && (sample_q == cand_q)) ? cand_cnt_q + 1'b1 : DCNT_W'(1);
          if (cnt_next >= DCNT_W'(DEBOUNCE_CNT)) begin
            fire         = 1'b1;
            cand_valid_d = 1'b0;
            cand_cnt_d   = '0;
          end else begin
            cand_d       = sample_q;
            cand_cnt_d   = cnt_next;
            cand_valid_d = 1'b1;
          end
`else
          fire = 1'b1;
`endif
        end
`ifdef PIO_POLLER_DEBOUNCE_EN
        else begin
          cand_valid_d = 1'b0;
          cand_cnt_d   = '0;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    // A pending, unaccepted event is merged: new data, accumulated mask, sticky overrun.
    if (fire) begin
      chg_data_d  = sample_q;
      cur_value_d = sample_q;
      chg_valid_d = 1'b1;
      if (chg_valid_q && !chg_ready) begin
        chg_mask_d = chg_mask_q | (sample_q ^ cur_value_q);
        overrun_d  = 1'b1;
      end else begin
        chg_mask_d = sample_q ^ cur_value_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      poll_cnt_q  <= PollReload;
      lat_cnt_q   <= '0;
      sample_q    <= '0;
      cur_value_q <= '0;
      primed_q    <= 1'b0;
      chg_data_q  <= '0;
      chg_mask_q  <= '0;
      chg_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      poll_cnt_q  <= poll_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      sample_q    <= sample_d;
      cur_value_q <= cur_value_d;
      primed_q    <= primed_d;
      chg_data_q  <= chg_data_d;
      chg_mask_q  <= chg_mask_d;
      chg_valid_q <= chg_valid_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef PIO_POLLER_DEBOUNCE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q       <= '0;
      cand_cnt_q   <= '0;
      cand_valid_q <= 1'b0;
    end else begin
      cand_q       <= cand_d;
      cand_cnt_q   <= cand_cnt_d;
      cand_valid_q <= cand_valid_d;
    end
  end
`endif

  generate
    if (DATA_W < 32) begin : g_unused_rd
      logic unused_readdata;
      assign unused_readdata = ^avm_readdata[31:DATA_W];
    end
  endgenerate

  assign avm_read    = (state_q == StReq);
  assign avm_address = avm_read ? PollAddr : '0;
  assign cur_value   = cur_value_q;
  assign chg_data    = chg_data_q;
  assign chg_mask    = chg_mask_q;
  assign chg_valid   = chg_valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_finalprojectsoc_pio_poller.sv
// Scoreboard bench for finalprojectsoc_pio_poller: a PIO slave model, an event monitor
// that pops expected change events, and directed scenarios (POLL_DIV=4, READ_LATENCY=1).
module tb_finalprojectsoc_pio_poller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic [9:0]  cur_value, chg_data, chg_mask;
  logic        chg_valid, overrun;
  logic        chg_ready = 1'b1;
  logic        clr_overrun = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [9:0]  slave_val  = 10'h155;
  logic [21:0] upper_fill = '0;
  int          ws_left    = 0;
  bit          acc_seen   = 1'b0;
  int          reads_done = 0;

  logic [9:0] exp_data_q[$];
  logic [9:0] exp_mask_q[$];

  int   cyc = 0, last_start = -1, period = 0, run = 0, last_len = 0, read_cnt = 0;
  logic rd_prev = 1'b0;

  finalprojectsoc_pio_poller #(
    .DATA_W(10), .ADDR_W(2), .POLL_ADDR(0), .POLL_DIV(4), .READ_LATENCY(1), .DEBOUNCE_CNT(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .cur_value      (cur_value),
    .chg_data       (chg_data),
    .chg_mask       (chg_mask),
    .chg_valid      (chg_valid),
    .chg_ready      (chg_ready),
    .overrun        (overrun),
    .clr_overrun    (clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave: readdata is valid only in the cycle after acceptance; other cycles carry inverted data.
  always @(posedge clk) begin
    #1;
    if (acc_seen) begin
      avm_readdata = {upper_fill, slave_val};
      reads_done++;
    end else begin
      avm_readdata = {upper_fill, ~slave_val};
    end
    acc_seen = 1'b0;
    if (avm_read && ws_left > 0) begin
      avm_waitrequest = 1'b1;
      ws_left--;
    end else begin
      avm_waitrequest = 1'b0;
    end
  end

  // Monitor: read timing, address, and scoreboard pop on every accepted change event.
  always @(negedge clk) begin
    cyc++;
    if (avm_read) check("avm_address", 32'(avm_address), 32'h0);
    if (avm_read && !rd_prev) begin
      if (last_start >= 0) period = cyc - last_start;
      last_start = cyc;
      read_cnt++;
    end
    if (avm_read) run++;
    else if (rd_prev) begin
      last_len = run;
      run = 0;
    end
    rd_prev = avm_read;
    if (avm_read && !avm_waitrequest) acc_seen = 1'b1;
    if (chg_valid && chg_ready) begin
      if (exp_data_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got data=0x%0h mask=0x%0h expected no event",
                 chg_data, chg_mask);
      end else begin
        check("event_data", 32'(chg_data), 32'(exp_data_q.pop_front()));
        check("event_mask", 32'(chg_mask), 32'(exp_mask_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of the cycle after CAPTURE, when the poll result is visible.
  task automatic wait_poll();
    int target;
    bit ok;
    target = reads_done + 1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (reads_done >= target) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL poll_timeout: reads_done=%0d expected %0d", reads_done, target);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_read(input bit need_accept);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (avm_read && (!need_accept || !avm_waitrequest)) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL read_timeout: avm_read=%0b expected 1", avm_read);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cur_value", 32'(cur_value), 32'h0);
    check("rst_chg_valid", 32'(chg_valid), 32'h0);
    check("rst_chg_data", 32'(chg_data), 32'h0);
    check("rst_chg_mask", 32'(chg_mask), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_avm_read", 32'(avm_read), 32'h0);
    check("rst_avm_address", 32'(avm_address), 32'h0);

    // Priming and poll period.
    step(); reset = 1'b0; enable = 1'b1;
    wait_poll();
    check("prime_cur_value", 32'(cur_value), 32'h155);
    check("prime_no_event", 32'(chg_valid), 32'h0);
    wait_poll();
    check("poll_period", 32'(period), 32'd7);
    check("read_len", 32'(last_len), 32'd1);

    // Single change event, consumer ready.
    step(); slave_val = 10'h154;
    exp_data_q.push_back(10'h154); exp_mask_q.push_back(10'h001);
    wait_poll();
    check("chg_cur_value", 32'(cur_value), 32'h154);
    check("chg_valid_set", 32'(chg_valid), 32'h1);
    check("chg_overrun", 32'(overrun), 32'h0);
    @(negedge clk);
    check("chg_valid_one_cycle", 32'(chg_valid), 32'h0);

    // Overrun: two events stack while consumer is stalled.
    step(); slave_val = 10'h000;
    exp_data_q.push_back(10'h000); exp_mask_q.push_back(10'h154);
    wait_poll();
    check("ovr_cur_zero", 32'(cur_value), 32'h0);
    step(); chg_ready = 1'b0; slave_val = 10'h003;
    wait_poll();
    check("ovr_first_valid", 32'(chg_valid), 32'h1);
    check("ovr_first_data", 32'(chg_data), 32'h003);
    check("ovr_first_mask", 32'(chg_mask), 32'h003);
    check("ovr_first_flag", 32'(overrun), 32'h0);
    step(); slave_val = 10'h00C;
    wait_poll();
    check("ovr_data", 32'(chg_data), 32'h00C);
    check("ovr_mask", 32'(chg_mask), 32'h00F);
    check("ovr_flag", 32'(overrun), 32'h1);
    exp_data_q.push_back(10'h00C); exp_mask_q.push_back(10'h00F);
    step(); chg_ready = 1'b1; clr_overrun = 1'b1;
    step(); clr_overrun = 1'b0;
    @(negedge clk);
    check("ovr_cleared", 32'(overrun), 32'h0);
    check("ovr_accepted", 32'(chg_valid), 32'h0);

    // Waitrequest stall with junk in upper readdata bits.
    step(); ws_left = 3; upper_fill = '1; slave_val = 10'h2A5;
    exp_data_q.push_back(10'h2A5); exp_mask_q.push_back(10'h2A9);
    wait_poll();
    check("ws_cur_value", 32'(cur_value), 32'h2A5);
    check("ws_read_len", 32'(last_len), 32'd4);

    // Reset while in WAIT, then re-prime without an event.
    step(); upper_fill = '0; slave_val = 10'h0F0;
    wait_read(1'b1);
    step(); reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_avm_read", 32'(avm_read), 32'h0);
    check("mid_rst_cur_value", 32'(cur_value), 32'h0);
    check("mid_rst_chg_valid", 32'(chg_valid), 32'h0);
    check("mid_rst_chg_data", 32'(chg_data), 32'h0);
    check("mid_rst_chg_mask", 32'(chg_mask), 32'h0);
    check("mid_rst_overrun", 32'(overrun), 32'h0);
    step(); reset = 1'b0;
    wait_poll();
    check("reprime_cur_value", 32'(cur_value), 32'h0F0);
    check("reprime_no_event", 32'(chg_valid), 32'h0);

    // Enable dropped while REQ is stalled: transaction completes, then polling stops.
    step(); slave_val = 10'h0FF; ws_left = 2;
    exp_data_q.push_back(10'h0FF); exp_mask_q.push_back(10'h00F);
    wait_read(1'b0);
    step(); enable = 1'b0;
    wait_poll();
    check("dis_cur_value", 32'(cur_value), 32'h0FF);
    n = read_cnt;
    repeat (30) @(negedge clk);
    check("dis_no_more_reads", 32'(read_cnt - n), 32'h0);

    check("scoreboard_empty", 32'(exp_data_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
